// File: rtl/rbm_iter_accum.sv
// Iterative accumulator for an RBM layer chain: restarts the chain, sums each
// channel's result with saturation, and picks the winning class with optional margin stop.
module rbm_iter_accum #(
    parameter int bitlength     = 12,
    parameter int output_dim    = 2,
    parameter int acc_bitlength = 16,
    parameter int iter_width    = 16,
    localparam int CIDX_W = (output_dim > 1) ? $clog2(output_dim) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [iter_width-1:0]               iter_num,
    input  logic                                margin_en,
    input  logic [acc_bitlength-1:0]            margin,
    output logic                                layer_reset,
    input  logic                                layer_finish,
    input  logic [output_dim*bitlength-1:0]     LayerData,
    output logic [output_dim*acc_bitlength-1:0] OutputData,
    output logic [CIDX_W-1:0]                   class_idx,
    output logic [iter_width-1:0]               iter_count,
    output logic                                busy,
    output logic                                finish
);
    typedef enum logic [1:0] {IDLE, CLEAR, WAIT, DONE} state_t;

    localparam int AW1 = acc_bitlength + 1;
    localparam logic signed [acc_bitlength:0] SAT_MAX = $signed({2'b00, {(acc_bitlength-1){1'b1}}});
    localparam logic signed [acc_bitlength:0] SAT_MIN = -SAT_MAX;

    state_t                          state_q, state_d;
    logic [iter_width-1:0]           iter_num_q, iter_num_d;
    logic                            margin_en_q, margin_en_d;
    logic [acc_bitlength-1:0]        margin_q, margin_d;
    logic signed [acc_bitlength-1:0] acc_q [output_dim];
    logic signed [acc_bitlength-1:0] acc_d [output_dim];
    logic [iter_width-1:0]           iter_count_q, iter_count_d;
    logic [CIDX_W-1:0]               class_idx_q, class_idx_d;
    logic                            layer_reset_q, layer_reset_d;
    logic                            busy_q, busy_d;
    logic                            finish_q, finish_d;

    logic signed [acc_bitlength-1:0] acc_sum [output_dim];
    logic signed [acc_bitlength:0]   sum_wide;
    logic signed [bitlength-1:0]     layer_ch;
    logic signed [acc_bitlength-1:0] best_val, second_val;
    logic [CIDX_W-1:0]               best_idx;
    logic [acc_bitlength:0]          lead;
    logic [iter_width-1:0]           count_inc;
    logic                            stop_now;

    always_comb begin
        layer_ch = '0;
        sum_wide = '0;
        for (int g = 0; g < output_dim; g++) begin
            layer_ch = LayerData[g*bitlength +: bitlength];
            sum_wide = AW1'(acc_q[g]) + AW1'(layer_ch);
            if (sum_wide > SAT_MAX)
                acc_sum[g] = SAT_MAX[acc_bitlength-1:0];
            else if (sum_wide < SAT_MIN)
                acc_sum[g] = SAT_MIN[acc_bitlength-1:0];
            else
                acc_sum[g] = sum_wide[acc_bitlength-1:0];
        end

        best_idx = '0;
        best_val = acc_sum[0];
        for (int g = 1; g < output_dim; g++) begin
            if (acc_sum[g] > best_val) begin
                best_val = acc_sum[g];
                best_idx = CIDX_W'(g);
            end
        end

        // The most-negative code is never produced by saturation, so it serves as -infinity
        second_val = {1'b1, {(acc_bitlength-1){1'b0}}};
        for (int g = 0; g < output_dim; g++) begin
            if ((CIDX_W'(g) != best_idx) && (acc_sum[g] > second_val))
                second_val = acc_sum[g];
        end

        lead      = AW1'(best_val) - AW1'(second_val);
        count_inc = iter_count_q + iter_width'(1);
        stop_now  = (count_inc == iter_num_q) ||
                    (margin_en_q && (lead >= {1'b0, margin_q}));
    end

    always_comb begin
        state_d      = state_q;
        iter_num_d   = iter_num_q;
        margin_en_d  = margin_en_q;
        margin_d     = margin_q;
        acc_d        = acc_q;
        iter_count_d = iter_count_q;
        class_idx_d  = class_idx_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    iter_num_d   = iter_num;
                    margin_en_d  = margin_en;
                    margin_d     = margin;
                    for (int g = 0; g < output_dim; g++)
                        acc_d[g] = '0;
                    iter_count_d = '0;
                    class_idx_d  = '0;
                    state_d      = (iter_num == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: state_d = WAIT;
            WAIT: begin
                if (layer_finish) begin
                    acc_d        = acc_sum;
                    iter_count_d = count_inc;
                    class_idx_d  = best_idx;
                    state_d      = stop_now ? DONE : CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase

        layer_reset_d = (state_d == CLEAR);
        busy_d        = (state_d == CLEAR) || (state_d == WAIT);
        finish_d      = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            iter_num_q    <= '0;
            margin_en_q   <= 1'b0;
            margin_q      <= '0;
            for (int g = 0; g < output_dim; g++)
                acc_q[g] <= '0;
            iter_count_q  <= '0;
            class_idx_q   <= '0;
            layer_reset_q <= 1'b0;
            busy_q        <= 1'b0;
            finish_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            iter_num_q    <= iter_num_d;
            margin_en_q   <= margin_en_d;
            margin_q      <= margin_d;
            acc_q         <= acc_d;
            iter_count_q  <= iter_count_d;
            class_idx_q   <= class_idx_d;
            layer_reset_q <= layer_reset_d;
            busy_q        <= busy_d;
            finish_q      <= finish_d;
        end
    end

    for (genvar g = 0; g < output_dim; g++) begin : g_pack
        assign OutputData[g*acc_bitlength +: acc_bitlength] = acc_q[g];
    end

    assign class_idx   = class_idx_q;
    assign iter_count  = iter_count_q;
    assign layer_reset = layer_reset_q;
    assign busy        = busy_q;
    assign finish      = finish_q;

endmodule
